// File: rtl/sbox_pkg.sv
// GF(2^4)/GF((2^4)^2) arithmetic, basis-change matrices and AES affine transforms for the S-box pipeline.
// Basis-change matrices are derived at elaboration time from lambda and the AES field polynomial.
package sbox_pkg;

  // x^2 + x + LAMBDA is irreducible over GF(2^4) = GF(2)[w]/(w^4 + w + 1) since Tr(LAMBDA) = 1
  localparam logic [3:0] LAMBDA     = 4'hC;
  localparam logic [7:0] AFF_TAPS   = 8'h1F;
  localparam logic [7:0] AFF_C      = 8'h63;
  localparam logic [7:0] INV_AFF_TAPS = 8'h4A;
  localparam logic [7:0] INV_AFF_C  = 8'h05;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^14 == a^-1 in GF(16); maps 0 to 0 for free
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] find_g();
    logic [7:0] g;
    logic [7:0] c, c2, c4;
    g = 8'h00;
    for (int i = 2; i < 256; i++) begin
      c  = 8'(i);
      c2 = gf8_mul(c, c);
      c4 = gf8_mul(c2, c2);
      if ((c4 ^ c ^ 8'h01) == 8'h00 && g == 8'h00) g = c;
    end
    return g;
  endfunction

  function automatic logic [7:0] embed(input logic [3:0] a, input logic [7:0] g);
    logic [7:0] e;
    logic [7:0] pw;
    e  = 8'h00;
    pw = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) e ^= pw;
      pw = gf8_mul(pw, g);
    end
    return e;
  endfunction

  function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int k = 0; k < 8; k++)
      if (x[k]) y ^= m[8*k +: 8];
    return y;
  endfunction

  // Columns: lo bit j -> g^j, hi bit j -> beta*g^j, with beta a root of x^2 + x + lambda
  function automatic logic [63:0] build_iso_inv();
    logic [63:0] m;
    logic [7:0]  g, lam, beta, b, e;
    logic [3:0]  u;
    g    = find_g();
    lam  = embed(LAMBDA, g);
    beta = 8'h00;
    for (int i = 2; i < 256; i++) begin
      b = 8'(i);
      if ((gf8_mul(b, b) ^ b ^ lam) == 8'h00 && beta == 8'h00) beta = b;
    end
    m = 64'h0;
    for (int j = 0; j < 4; j++) begin
      u = 4'h1 << j;
      e = embed(u, g);
      m[8*j +: 8]     = e;
      m[8*(j+4) +: 8] = gf8_mul(beta, e);
    end
    return m;
  endfunction

  function automatic logic [63:0] build_iso();
    logic [63:0] inv_m, m;
    logic [7:0]  v, w;
    inv_m = build_iso_inv();
    m     = 64'h0;
    for (int i = 1; i < 256; i++) begin
      v = 8'(i);
      w = mat_apply(inv_m, v);
      for (int k = 0; k < 8; k++)
        if (w == (8'h01 << k)) m[8*k +: 8] = v;
    end
    return m;
  endfunction

  localparam logic [63:0] ISO_INV_M = build_iso_inv();
  localparam logic [63:0] ISO_M     = build_iso();

  function automatic logic [7:0] iso_map(input logic [7:0] x);
    return mat_apply(ISO_M, x);
  endfunction

  function automatic logic [7:0] iso_inv_map(input logic [7:0] x);
    return mat_apply(ISO_INV_M, x);
  endfunction

  // Both affine matrices are circulant: XOR of left-rotations selected by the tap mask
  function automatic logic [7:0] circ(input logic [7:0] x, input logic [7:0] taps);
    logic [7:0] y;
    logic [15:0] xx;
    y  = 8'h00;
    xx = {x, x};
    for (int k = 0; k < 8; k++)
      if (taps[k]) y ^= xx[8-k +: 8];
    return y;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return circ(x, AFF_TAPS) ^ AFF_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return circ(x, INV_AFF_TAPS) ^ INV_AFF_C;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of the 3-stage S-box datapath; all stages advance together on en.
// mode feeds S1 (inverse affine), mode_s2 is the beat's mode as it enters S3 (forward affine).
module sbox_lane
  import sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       mode_s2,
  input  logic [7:0] data,
  output logic [7:0] result
);

  logic [7:0] src, iso;
  logic [3:0] hi, lo;
  logic [3:0] s1_hi, s1_hl, s1_delta;
  logic [3:0] s2_hi, s2_hl, s2_inv;
  logic [7:0] s3_inv;

  assign src    = mode ? inv_affine(data) : data;
  assign iso    = iso_map(src);
  assign hi     = iso[7:4];
  assign lo     = iso[3:0];
  assign s3_inv = iso_inv_map({gf4_mul(s2_hi, s2_inv), gf4_mul(s2_hl, s2_inv)});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hi    <= '0;
      s1_hl    <= '0;
      s1_delta <= '0;
      s2_hi    <= '0;
      s2_hl    <= '0;
      s2_inv   <= '0;
      result   <= '0;
    end else if (en) begin
      s1_hi    <= hi;
      s1_hl    <= hi ^ lo;
      s1_delta <= gf4_mul(gf4_sq(hi), LAMBDA) ^ gf4_mul(hi ^ lo, lo);
      s2_hi    <= s1_hi;
      s2_hl    <= s1_hl;
      s2_inv   <= gf4_inv(s1_delta);
      result   <= mode_s2 ? s3_inv : affine(s3_inv);
    end
  end

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane pipelined AES S-box (forward/inverse per beat), 3-cycle latency, one beat per cycle.
// A stalled output freezes every stage; flush drops all in-flight beats on the next edge.
module sbox_pipe
  import sbox_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               flush,
  output logic               busy
);

  logic             advance;
  logic             s1_valid, s2_valid;
  logic             s1_mode, s2_mode;
  logic [TAG_W-1:0] s1_tag, s2_tag;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;
  assign busy     = s1_valid || s2_valid || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_mode   <= 1'b0;
      s2_mode   <= 1'b0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      out_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (advance) begin
        s1_valid  <= in_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
      end
      if (advance) begin
        s1_mode <= in_mode;
        s1_tag  <= in_tag;
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
        out_tag <= s2_tag;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (advance),
      .mode    (in_mode),
      .mode_s2 (s2_mode),
      .data    (in_data[8*i +: 8]),
      .result  (out_data[8*i +: 8])
    );
  end

endmodule
